multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multi-cycle control unit for the single-cycle-datapath CPU. It sequences fetch, decode, execute, memory and write-back as a state machine, and drives the same ALU, mux, register-file, memory and PC/branch enables as the existing controller. It adds:
- ready handshakes to the instruction and data memories, allowing multi-cycle memories;
- an internally latched instruction register;
- a memory-wait timeout;
- illegal-opcode trapping;
- a retired-instruction counter.

## Interface
- `IW`, default 32: instruction width. Opcode is `ir[IW-2:IW-7]`; `sub5 = ir[4:0]`; `sub8 = ir[7:0]`; `sv = ir[9:8]`.
- `ALU_SEL_W`, default 5: width of `alu_sel`.
- `MAX_WAIT`, default 15: maximum cycles spent waiting for `IM_ready`/`DM_ready` before trapping. Must be ≥ 1.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: clock. Rising-edge.
- `rst` in 1: reset. Synchronous, active-low.
- `ir_in` in IW: instruction word from the instruction memory. Sampled when `IM_ready` is high during FETCH.
- `IM_ready` in 1: instruction-memory read complete.
- `DM_ready` in 1: data-memory access complete.
- `IM_enable`, `IM_read` out 1: instruction-fetch request.
- `DM_enable`, `DM_read`, `DM_write` out 1: data-memory request.
- `reg_enable`, `reg_read`, `reg_write` out 1: register-file controls.
- `alu_enable` out 1: ALU enable.
- `alu_sel` out ALU_SEL_W: ALU operation select.
- `sv` out 2: shift amount field, equal to `ir[9:8]` of the latched IR.
- `mux4to1_sel`, `mux2to1_sel`, `imm_reg_sel` out 2: datapath select lines.
- `PC_enable`, `B_enable`, `J_enable` out 1: PC update, branch and jump enables.
- `ir_q` out IW: latched instruction register.
- `illegal` out 1: sticky flag, set on an illegal opcode.
- `bus_err` out 1: sticky flag, set on a memory-wait timeout.
- `halted` out 1: controller is in HALT.
- `retired` out CNT_W: count of completed instructions.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- All outputs are Moore outputs, decoded from the state and `ir_q`.
- Every output not listed for a state is 0. No output is ever held over from a previous state.
- FETCH:
  - `IM_enable = IM_read = 1`.
  - When `IM_ready` is high: `ir_q <= ir_in`, then go to DECODE.
- DECODE:
  - `reg_enable = reg_read = 1`.
  - If the opcode is illegal, go to HALT and set `illegal`. Otherwise go to EXEC.
  - Legal opcodes: 100000, 101000, 101100, 101011, 100010, 011100, 000010, 001010, 100110, 100111, 100100.
  - 011100 is also illegal unless `sub8` is 0x02 or 0x0A.
- EXEC: per-opcode selects.

| Opcode | Instruction | alu_enable | alu_sel | mux4to1_sel | mux2to1_sel |
|---|---|---|---|---|---|
| 100000 | ALU op | 1 | `sub5` | 00 | 01 if `sub5` ∈ {01000, 01001, 01011}, else 00 |
| 101000 | — | 1 | 00000 | 01 | 01 |
| 101100 | — | 1 | 00100 | 10 | 01 |
| 101011 | — | 1 | 00011 | 10 | 01 |
| 100010 | MOVI | 0 | 0 | 11 | 01 |
| 011100 | LW / SW | 1 | 10000 | 00 | 00 |
| 000010 | LWI | 1 | 10001 | 01 | 01 |
| 001010 | SWI | 1 | 10001 | 01 | 01 |
| 100110 | — | 1 | 00001 | 01 | 10 |
| 100111 | — | 1 | 10010 | 01 | 10 |
| 100100 | — | 1 | 10010 | 01 | 10 |

  - Memory ops (011100, 000010, 001010) go to MEM. All other opcodes go to WB.
- MEM:
  - `DM_enable = 1`.
  - `DM_read = 1` for LW (`sub8` = 0x02) and LWI.
  - `DM_write = 1` for SW (`sub8` = 0x0A) and SWI.
  - The EXEC `alu_enable`, `alu_sel` and mux selects are held.
  - When `DM_ready` is high, go to WB.
- WB:
  - `PC_enable = 1`.
  - For 100010, 100000, 101000, 101100, 101011, LW and LWI: `reg_enable = reg_write = 1`.
  - `imm_reg_sel` is 10 for LW/LWI, 01 for the ALU and immediate ops, 00 for MOVI, and 11 otherwise.
  - `B_enable = 1` for 100110 and 100111. `J_enable = 1` for 100100.
  - `retired <= retired + 1`, wrapping modulo 2^CNT_W.
  - Then go to FETCH.
- Wait counter, width `$clog2(MAX_WAIT+1)`:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle spent in FETCH or MEM without the corresponding ready.
  - If it reaches MAX_WAIT with ready still low, go to HALT and set `bus_err`.
  - A ready that arrives on the MAX_WAIT-th cycle wins over the timeout.
- HALT:
  - `halted = 1`. All request and enable outputs are 0.
  - HALT is left only by reset.
- `sv` always equals `ir_q[9:8]`.

## Timing
- Reset (`rst == 0` at a clock edge), from any state including mid-handshake:
  - State goes to FETCH.
  - `ir_q`, `retired`, `illegal`, `bus_err` and the wait counter are cleared to 0.
  - All outputs are 0 while `rst` is low.
  - In the first cycle after `rst` goes high, `IM_enable = 1`.
- Latency with zero-wait memories (ready high on the first request cycle):
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Memory instruction: 5 cycles.
  - Each wait cycle adds exactly 1.
- `ir_in` is sampled only on the FETCH cycle in which `IM_ready` is high. `ir_q` is stable from that point until the next fetch completes.
- `IM_ready` is ignored outside FETCH, and `DM_ready` is ignored outside MEM.
- `retired` updates on the edge that leaves WB.

## Test plan
- Reset, then ADDI (opcode 101000) with `IM_ready` tied to 1:
  - EXEC shows `alu_sel` 00000, `mux4to1_sel` 01, `mux2to1_sel` 01.
  - WB shows `reg_write` 1, `imm_reg_sel` 01, `PC_enable` 1.
  - `retired` = 1 after 4 cycles.
- LW (011100, `sub8` 0x02) with `DM_ready` delayed 3 cycles:
  - MEM lasts 4 cycles with `DM_read` 1 and `DM_write` 0.
  - WB shows `imm_reg_sel` 10.
  - Total latency 8 cycles.
- SWI (001010):
  - MEM shows `DM_write` 1 and `DM_read` 0.
  - WB shows `reg_write` 0 and `imm_reg_sel` 11.
- Opcode 111111:
  - DECODE goes to HALT; `illegal` = 1, `halted` = 1, `PC_enable` stays 0.
  - Toggling `IM_ready` has no effect.
  - Reset clears `illegal` and `halted`.
- `IM_ready` held low for MAX_WAIT = 15 cycles: `bus_err` = 1 and the controller is in HALT.
- `IM_ready` rising on cycle 15: no error; the fetch completes.
- J (100100) then BEQ (100110):
  - J's WB shows `J_enable` 1 and `B_enable` 0.
  - BEQ's WB shows `B_enable` 1 and `J_enable` 0.
- `retired` is preset to all-ones through 2^CNT_W − 1 completed instructions; the next retirement wraps it to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// ready handshakes, wait timeout, illegal-opcode trap and retired-instruction count.
module multicycle_ctrl #(
  parameter int IW        = 32,
  parameter int ALU_SEL_W = 5,
  parameter int MAX_WAIT  = 15,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IW-1:0]        ir_in,
  input  logic                 IM_ready,
  input  logic                 DM_ready,
  output logic                 IM_enable,
  output logic                 IM_read,
  output logic                 DM_enable,
  output logic                 DM_read,
  output logic                 DM_write,
  output logic                 reg_enable,
  output logic                 reg_read,
  output logic                 reg_write,
  output logic                 alu_enable,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic [1:0]           sv,
  output logic [1:0]           mux4to1_sel,
  output logic [1:0]           mux2to1_sel,
  output logic [1:0]           imm_reg_sel,
  output logic                 PC_enable,
  output logic                 B_enable,
  output logic                 J_enable,
  output logic [IW-1:0]        ir_q,
  output logic                 illegal,
  output logic                 bus_err,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [5:0] OP_ALU    = 6'b100000;
  localparam logic [5:0] OP_ADDI   = 6'b101000;
  localparam logic [5:0] OP_IMM4   = 6'b101100;
  localparam logic [5:0] OP_IMM3   = 6'b101011;
  localparam logic [5:0] OP_MOVI   = 6'b100010;
  localparam logic [5:0] OP_LWSW   = 6'b011100;
  localparam logic [5:0] OP_LWI    = 6'b000010;
  localparam logic [5:0] OP_SWI    = 6'b001010;
  localparam logic [5:0] OP_BR_A   = 6'b100110;
  localparam logic [5:0] OP_BR_B   = 6'b100111;
  localparam logic [5:0] OP_JMP    = 6'b100100;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      instr_q, instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  logic [5:0]           opcode;
  logic [4:0]           sub5;
  logic [7:0]           sub8;
  logic                 is_legal, is_mem, mem_rd, mem_wr;
  logic                 ex_alu_en;
  logic [ALU_SEL_W-1:0] ex_alu_sel;
  logic [1:0]           ex_mux4, ex_mux2;
  logic                 wb_reg_wr, wb_b, wb_j;
  logic [1:0]           wb_imm;
  logic                 wait_expired;

  assign opcode       = instr_q[IW-2:IW-7];
  assign sub5         = instr_q[4:0];
  assign sub8         = instr_q[7:0];
  assign wait_expired = (wait_q == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    is_legal   = 1'b1;
    is_mem     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ex_alu_en  = 1'b1;
    ex_alu_sel = '0;
    ex_mux4    = 2'b00;
    ex_mux2    = 2'b00;
    wb_reg_wr  = 1'b0;
    wb_imm     = 2'b11;
    wb_b       = 1'b0;
    wb_j       = 1'b0;
    case (opcode)
      OP_ALU: begin
        ex_alu_sel = ALU_SEL_W'(sub5);
        ex_mux2    = (sub5 == 5'b01000 || sub5 == 5'b01001 || sub5 == 5'b01011) ? 2'b01 : 2'b00;
        wb_reg_wr  = 1'b1;
        wb_imm     = 2'b01;
      end
      OP_ADDI: begin
        ex_mux4   = 2'b01;
        ex_mux2   = 2'b01;
        wb_reg_wr = 1'b1;
        wb_imm    = 2'b01;
      end
      OP_IMM4, OP_IMM3: begin
        ex_alu_sel = (opcode == OP_IMM4) ? ALU_SEL_W'(5'b00100) : ALU_SEL_W'(5'b00011);
        ex_mux4    = 2'b10;
        ex_mux2    = 2'b01;
        wb_reg_wr  = 1'b1;
        wb_imm     = 2'b01;
      end
      OP_MOVI: begin
        ex_alu_en = 1'b0;
        ex_mux4   = 2'b11;
        ex_mux2   = 2'b01;
        wb_reg_wr = 1'b1;
        wb_imm    = 2'b00;
      end
      OP_LWSW: begin
        // Only the LW/SW sub-functions are defined for this opcode
        is_legal   = (sub8 == 8'h02) || (sub8 == 8'h0A);
        is_mem     = 1'b1;
        mem_rd     = (sub8 == 8'h02);
        mem_wr     = (sub8 == 8'h0A);
        ex_alu_sel = ALU_SEL_W'(5'b10000);
        wb_reg_wr  = mem_rd;
        wb_imm     = mem_rd ? 2'b10 : 2'b11;
      end
      OP_LWI, OP_SWI: begin
        is_mem     = 1'b1;
        mem_rd     = (opcode == OP_LWI);
        mem_wr     = (opcode == OP_SWI);
        ex_alu_sel = ALU_SEL_W'(5'b10001);
        ex_mux4    = 2'b01;
        ex_mux2    = 2'b01;
        wb_reg_wr  = mem_rd;
        wb_imm     = mem_rd ? 2'b10 : 2'b11;
      end
      OP_BR_A, OP_BR_B, OP_JMP: begin
        ex_alu_sel = (opcode == OP_BR_A) ? ALU_SEL_W'(5'b00001) : ALU_SEL_W'(5'b10010);
        ex_mux4    = 2'b01;
        ex_mux2    = 2'b10;
        wb_b       = (opcode != OP_JMP);
        wb_j       = (opcode == OP_JMP);
      end
      default: is_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    wait_d    = wait_q;
    case (state_q)
      S_FETCH: begin
        // A ready on the last allowed cycle takes priority over the timeout
        if (IM_ready) begin
          instr_d = ir_in;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        wait_d  = '0;
        state_d = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (DM_ready) begin
          state_d = S_WB;
        end else if (wait_expired) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        retired_d = retired_q + CNT_W'(1);
        wait_d    = '0;
        state_d   = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      instr_q   <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      wait_q    <= wait_d;
    end
  end

  // Every output, including the register views, reads as zero while reset is asserted
  assign ir_q    = rst ? instr_q : '0;
  assign retired = rst ? retired_q : '0;
  assign illegal = rst & illegal_q;
  assign bus_err = rst & bus_err_q;
  assign sv      = ir_q[9:8];

  always_comb begin
    IM_enable   = 1'b0;
    IM_read     = 1'b0;
    DM_enable   = 1'b0;
    DM_read     = 1'b0;
    DM_write    = 1'b0;
    reg_enable  = 1'b0;
    reg_read    = 1'b0;
    reg_write   = 1'b0;
    alu_enable  = 1'b0;
    alu_sel     = '0;
    mux4to1_sel = 2'b00;
    mux2to1_sel = 2'b00;
    imm_reg_sel = 2'b00;
    PC_enable   = 1'b0;
    B_enable    = 1'b0;
    J_enable    = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          IM_enable = 1'b1;
          IM_read   = 1'b1;
        end
        S_DECODE: begin
          reg_enable = 1'b1;
          reg_read   = 1'b1;
        end
        S_EXEC, S_MEM: begin
          alu_enable  = ex_alu_en;
          alu_sel     = ex_alu_sel;
          mux4to1_sel = ex_mux4;
          mux2to1_sel = ex_mux2;
          DM_enable   = (state_q == S_MEM);
          DM_read     = (state_q == S_MEM) & mem_rd;
          DM_write    = (state_q == S_MEM) & mem_wr;
        end
        S_WB: begin
          PC_enable   = 1'b1;
          reg_enable  = wb_reg_wr;
          reg_write   = wb_reg_wr;
          imm_reg_sel = wb_imm;
          B_enable    = wb_b;
          J_enable    = wb_j;
        end
        S_HALT: halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level reference model expands each
// transaction into expected per-cycle outputs; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ir_in = '0;
  logic        IM_ready = 1'b0;
  logic        DM_ready = 1'b0;
  logic        IM_enable, IM_read, DM_enable, DM_read, DM_write;
  logic        reg_enable, reg_read, reg_write, alu_enable;
  logic [4:0]  alu_sel;
  logic [1:0]  sv, mux4to1_sel, mux2to1_sel, imm_reg_sel;
  logic        PC_enable, B_enable, J_enable;
  logic [31:0] ir_q;
  logic        illegal, bus_err, halted;
  logic [3:0]  retired;

  multicycle_ctrl #(.IW(32), .ALU_SEL_W(5), .MAX_WAIT(MAXW), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ir_in(ir_in), .IM_ready(IM_ready), .DM_ready(DM_ready),
    .IM_enable(IM_enable), .IM_read(IM_read), .DM_enable(DM_enable), .DM_read(DM_read),
    .DM_write(DM_write), .reg_enable(reg_enable), .reg_read(reg_read), .reg_write(reg_write),
    .alu_enable(alu_enable), .alu_sel(alu_sel), .sv(sv), .mux4to1_sel(mux4to1_sel),
    .mux2to1_sel(mux2to1_sel), .imm_reg_sel(imm_reg_sel), .PC_enable(PC_enable),
    .B_enable(B_enable), .J_enable(J_enable), .ir_q(ir_q), .illegal(illegal),
    .bus_err(bus_err), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       im_en, im_rd, dm_en, dm_rd, dm_wr, reg_en, reg_rd, reg_wr, alu_en;
    logic [4:0] alu_sel;
    logic [1:0] sv, mux4, mux2, imm;
    logic       pc, b, j;
    logic [31:0] ir;
    logic       illegal, bus_err, halted;
    logic [3:0] retired;
  } vec_t;

  typedef struct packed {
    logic       legal, mem, rd, wr, alu_en;
    logic [4:0] alu_sel;
    logic [1:0] mux4, mux2;
    logic       regw;
    logic [1:0] imm;
    logic       b, j;
  } info_t;

  vec_t  exp_q[$];
  string tag_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  logic [31:0] m_ir = '0;
  int          m_ret = 0;
  logic        m_ill = 1'b0;
  logic        m_bus = 1'b0;

  // Instruction semantics written straight from the opcode table
  function automatic info_t decodeInstr(input logic [31:0] w);
    info_t d;
    logic [5:0] op = w[30:25];
    logic [4:0] s5 = w[4:0];
    logic [7:0] s8 = w[7:0];
    d = '0;
    d.legal = 1'b1; d.alu_en = 1'b1; d.imm = 2'b11;
    case (op)
      6'b100000: begin d.alu_sel = s5; d.mux2 = (s5 == 8 || s5 == 9 || s5 == 11) ? 2'b01 : 2'b00;
                       d.regw = 1; d.imm = 2'b01; end
      6'b101000: begin d.alu_sel = 0;  d.mux4 = 1; d.mux2 = 1; d.regw = 1; d.imm = 2'b01; end
      6'b101100: begin d.alu_sel = 4;  d.mux4 = 2; d.mux2 = 1; d.regw = 1; d.imm = 2'b01; end
      6'b101011: begin d.alu_sel = 3;  d.mux4 = 2; d.mux2 = 1; d.regw = 1; d.imm = 2'b01; end
      6'b100010: begin d.alu_en = 0;   d.mux4 = 3; d.mux2 = 1; d.regw = 1; d.imm = 2'b00; end
      6'b011100: begin d.legal = (s8 == 8'h02 || s8 == 8'h0A); d.alu_sel = 16; d.mem = 1;
                       d.rd = (s8 == 8'h02); d.wr = (s8 == 8'h0A); d.regw = d.rd;
                       d.imm = d.rd ? 2'b10 : 2'b11; end
      6'b000010: begin d.alu_sel = 17; d.mux4 = 1; d.mux2 = 1; d.mem = 1; d.rd = 1; d.regw = 1;
                       d.imm = 2'b10; end
      6'b001010: begin d.alu_sel = 17; d.mux4 = 1; d.mux2 = 1; d.mem = 1; d.wr = 1; end
      6'b100110: begin d.alu_sel = 1;  d.mux4 = 1; d.mux2 = 2; d.b = 1; end
      6'b100111: begin d.alu_sel = 18; d.mux4 = 1; d.mux2 = 2; d.b = 1; end
      6'b100100: begin d.alu_sel = 18; d.mux4 = 1; d.mux2 = 2; d.j = 1; end
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [7:0] lo);
    logic [31:0] w = $urandom;
    w[30:25] = op;
    w[7:0]   = lo;
    return w;
  endfunction

  function automatic vec_t baseVec();
    vec_t v = '0;
    v.ir = m_ir; v.sv = m_ir[9:8];
    v.illegal = m_ill; v.bus_err = m_bus;
    v.retired = 4'(m_ret % 16);
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic imr, input logic dmr,
                               input logic [31:0] irin, input vec_t e, input string tag);
    @(posedge clk);
    #1;
    rst = r; IM_ready = imr; DM_ready = dmr; ir_in = irin;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic checkOutput(input string tag, input vec_t e);
    vec_t a;
    a = '{im_en: IM_enable, im_rd: IM_read, dm_en: DM_enable, dm_rd: DM_read, dm_wr: DM_write,
          reg_en: reg_enable, reg_rd: reg_read, reg_wr: reg_write, alu_en: alu_enable,
          alu_sel: alu_sel, sv: sv, mux4: mux4to1_sel, mux2: mux2to1_sel, imm: imm_reg_sel,
          pc: PC_enable, b: B_enable, j: J_enable, ir: ir_q, illegal: illegal,
          bus_err: bus_err, halted: halted, retired: retired};
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, a, e);
    end
  endtask

  initial begin
    vec_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checkOutput(t, e);
      end
    end
  end

  task automatic doReset(input string nm);
    for (int k = 0; k < 2; k++)
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), $urandom, '0, {nm, "_reset"});
    m_ir = '0; m_ret = 0; m_ill = 1'b0; m_bus = 1'b0;
  endtask

  task automatic haltThenReset(input string nm);
    vec_t e;
    for (int k = 0; k < 4; k++) begin
      e = baseVec(); e.halted = 1'b1;
      applyStimulus(1'b1, 1'($urandom), 1'($urandom), $urandom, e, {nm, "_halt"});
    end
    doReset(nm);
  endtask

  // One instruction: fw/mw are the number of not-ready cycles before each ready
  task automatic runInstr(input logic [31:0] w, input int fw, input int mw, input string nm);
    info_t d = decodeInstr(w);
    vec_t  e;
    for (int k = 0; k <= fw && k < MAXW; k++) begin
      e = baseVec(); e.im_en = 1; e.im_rd = 1;
      applyStimulus(1'b1, k == fw, 1'($urandom), (k == fw) ? w : $urandom, e, {nm, "_fetch"});
    end
    if (fw >= MAXW) begin m_bus = 1'b1; haltThenReset(nm); return; end
    m_ir = w;
    e = baseVec(); e.reg_en = 1; e.reg_rd = 1;
    applyStimulus(1'b1, 1'($urandom), 1'($urandom), $urandom, e, {nm, "_decode"});
    if (!d.legal) begin m_ill = 1'b1; haltThenReset(nm); return; end
    e = baseVec(); e.alu_en = d.alu_en; e.alu_sel = d.alu_sel; e.mux4 = d.mux4; e.mux2 = d.mux2;
    applyStimulus(1'b1, 1'($urandom), 1'($urandom), $urandom, e, {nm, "_exec"});
    if (d.mem) begin
      e.dm_en = 1; e.dm_rd = d.rd; e.dm_wr = d.wr;
      for (int k = 0; k <= mw && k < MAXW; k++)
        applyStimulus(1'b1, 1'($urandom), k == mw, $urandom, e, {nm, "_mem"});
      if (mw >= MAXW) begin m_bus = 1'b1; haltThenReset(nm); return; end
    end
    e = baseVec(); e.pc = 1; e.reg_en = d.regw; e.reg_wr = d.regw; e.imm = d.imm;
    e.b = d.b; e.j = d.j;
    applyStimulus(1'b1, 1'($urandom), 1'($urandom), $urandom, e, {nm, "_wb"});
    m_ret++;
  endtask

  function automatic logic [31:0] randLegal();
    logic [5:0] ops [11] = '{6'b100000, 6'b101000, 6'b101100, 6'b101011, 6'b100010,
                             6'b011100, 6'b000010, 6'b001010, 6'b100110, 6'b100111, 6'b100100};
    logic [5:0] op = ops[$urandom_range(0, 10)];
    logic [7:0] lo = 8'($urandom);
    if (op == 6'b011100) lo = $urandom_range(0, 1) ? 8'h02 : 8'h0A;
    return mkInstr(op, lo);
  endfunction

  function automatic int randWait();
    int r = $urandom_range(0, 29);
    if (r == 0) return MAXW;
    if (r == 1) return MAXW - 1;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t e;
    doReset("init");
    runInstr(mkInstr(6'b101000, 8'h35), 0, 0, "addi");
    runInstr(mkInstr(6'b011100, 8'h02), 0, 3, "lw");
    runInstr(mkInstr(6'b001010, 8'h77), 0, 0, "swi");
    runInstr(mkInstr(6'b100100, 8'h11), 0, 0, "jmp");
    runInstr(mkInstr(6'b100110, 8'h22), 0, 0, "beq");
    runInstr(mkInstr(6'b100000, 8'h09), 0, 0, "alu_mux2");
    runInstr(mkInstr(6'b100010, 8'h00), 2, 0, "movi");
    runInstr(mkInstr(6'b100000, 8'h03), MAXW - 1, 0, "late_fetch");
    runInstr(mkInstr(6'b111111, 8'h00), 0, 0, "illegal_op");
    runInstr(mkInstr(6'b011100, 8'h05), 0, 0, "illegal_sub8");
    runInstr(mkInstr(6'b101000, 8'h00), MAXW, 0, "fetch_timeout");
    runInstr(mkInstr(6'b000010, 8'h00), 0, MAXW - 1, "late_mem");
    runInstr(mkInstr(6'b000010, 8'h00), 0, MAXW, "mem_timeout");
    // Reset in the middle of a pending fetch handshake
    for (int k = 0; k < 3; k++) begin
      e = baseVec(); e.im_en = 1; e.im_rd = 1;
      applyStimulus(1'b1, 1'b0, 1'b0, $urandom, e, "midfetch_fetch");
    end
    doReset("midfetch");
    for (int i = 0; i < 17; i++) runInstr(randLegal(), $urandom_range(0, 2), $urandom_range(0, 2), "wrap");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) == 0) runInstr($urandom, randWait(), randWait(), "rand_any");
      else runInstr(randLegal(), randWait(), randWait(), "rand");
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
